// File: rtl/obstacle_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : obstacle_scheduler
//  Purpose  : Grants obstacle spawners one at a time, with frame gaps and grant timeout.
//  Revision : 1.0
// ============================================================================
module obstacle_scheduler #(
    parameter int NUM_SPAWNERS   = 4,
    parameter int RND_WIDTH      = 20,
    parameter int GAP_FRAMES     = 8,
    parameter int TIMEOUT_FRAMES = 64,
    parameter int SPAWN_PROB     = 26
) (
    input  logic                    CLK100MHZ,
    input  logic                    CPU_RESETN,
    input  logic                    enable,
    input  logic                    frame_tick,
    input  logic [RND_WIDTH-1:0]    random,
    input  logic [NUM_SPAWNERS-1:0] active,
    output logic [NUM_SPAWNERS-1:0] spawn_en,
    output logic                    busy,
    output logic                    fault,
    output logic [15:0]             spawn_count
);

    localparam int c_lane_w = $clog2(NUM_SPAWNERS);
    localparam int c_gap_w  = (GAP_FRAMES > 0) ? $clog2(GAP_FRAMES + 1) : 1;
    localparam int c_to_w   = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;

    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(NUM_SPAWNERS - 1);
    localparam logic [c_lane_w-1:0] c_lane_one  = c_lane_w'(1);
    localparam logic [c_lane_w:0]   c_num_lanes = (c_lane_w + 1)'(NUM_SPAWNERS);
    localparam logic [c_gap_w-1:0]  c_gap_load  = c_gap_w'(GAP_FRAMES);
    localparam logic [c_gap_w-1:0]  c_gap_one   = c_gap_w'(1);
    localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT_FRAMES - 1);
    localparam logic [c_to_w-1:0]   c_to_one    = c_to_w'(1);
    localparam logic [8:0]          c_prob      = 9'(SPAWN_PROB);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_COOLDOWN    = 3'd1,
        S_ARM         = 3'd2,
        S_WAIT_ACTIVE = 3'd3,
        S_RUN         = 3'd4
    } state_t;

    state_t                  r_state;
    logic [NUM_SPAWNERS-1:0] r_spawn_en;
    logic                    r_busy;
    logic                    r_fault;
    logic [15:0]             r_spawn_count;
    logic [c_lane_w-1:0]     r_rr_ptr;
    logic [c_gap_w-1:0]      r_gap_cnt;
    logic [c_to_w-1:0]       r_to_cnt;

    logic [c_lane_w-1:0]     w_sel;
    logic [c_lane_w-1:0]     w_lane;
    logic [c_lane_w-1:0]     w_next_rr;
    logic [7:0]              w_top;
    logic                    w_prob_ok;
    logic                    w_any_active;
    logic                    w_grant_hit;
    logic [NUM_SPAWNERS-1:0] w_onehot;
    logic [15:0]             w_count_inc;
    logic                    w_unused_rnd;

    // Out-of-range selector values fall back to the round-robin pointer.
    assign w_sel        = random[c_lane_w-1:0];
    assign w_lane       = ({1'b0, w_sel} < c_num_lanes) ? w_sel : r_rr_ptr;
    assign w_next_rr    = (w_lane == c_last_lane) ? '0 : w_lane + c_lane_one;
    assign w_top        = random[RND_WIDTH-1 -: 8];
    assign w_prob_ok    = ({1'b0, w_top} < c_prob);
    assign w_any_active = |active;
    assign w_grant_hit  = |(active & r_spawn_en);
    assign w_onehot     = NUM_SPAWNERS'(1) << w_lane;
    assign w_count_inc  = (r_spawn_count == 16'hFFFF) ? r_spawn_count : r_spawn_count + 16'd1;
    assign w_unused_rnd = ^random;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state       <= S_IDLE;
            r_spawn_en    <= '0;
            r_busy        <= 1'b0;
            r_fault       <= 1'b0;
            r_spawn_count <= '0;
            r_rr_ptr      <= '0;
            r_gap_cnt     <= '0;
            r_to_cnt      <= '0;
        end else begin
            r_fault <= 1'b0;
            if (!enable) begin
                r_state    <= S_IDLE;
                r_spawn_en <= '0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_spawn_en <= '0;
                        if (frame_tick) begin
                            r_state   <= S_COOLDOWN;
                            r_gap_cnt <= c_gap_load;
                        end
                    end
                    S_COOLDOWN: begin
                        if (frame_tick) begin
                            if (r_gap_cnt == '0 && !w_any_active) begin
                                r_state <= S_ARM;
                            end else if (r_gap_cnt != '0) begin
                                r_gap_cnt <= r_gap_cnt - c_gap_one;
                            end
                        end
                    end
                    S_ARM: begin
                        if (frame_tick && !w_any_active && w_prob_ok) begin
                            r_spawn_en <= w_onehot;
                            r_rr_ptr   <= w_next_rr;
                            r_to_cnt   <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= S_WAIT_ACTIVE;
                        end
                    end
                    S_WAIT_ACTIVE: begin
                        // The granted spawner coming up wins over a timeout on the same cycle.
                        if (w_grant_hit) begin
                            r_spawn_en    <= '0;
                            r_spawn_count <= w_count_inc;
                            r_state       <= S_RUN;
                        end else if (frame_tick) begin
                            if (r_to_cnt == c_to_last) begin
                                r_spawn_en <= '0;
                                r_fault    <= 1'b1;
                                r_busy     <= 1'b0;
                                r_gap_cnt  <= c_gap_load;
                                r_state    <= S_COOLDOWN;
                            end else begin
                                r_to_cnt <= r_to_cnt + c_to_one;
                            end
                        end
                    end
                    S_RUN: begin
                        if (!w_any_active) begin
                            r_busy    <= 1'b0;
                            r_gap_cnt <= c_gap_load;
                            r_state   <= S_COOLDOWN;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_spawn_en <= '0;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spawn_en    = r_spawn_en;
    assign busy        = r_busy;
    assign fault       = r_fault;
    assign spawn_count = r_spawn_count;

endmodule
`default_nettype wire
